// File: rtl/pong_pkg.sv
// Shared pong definitions: matrix geometry, row index type and scan states.
package pong_pkg;

    localparam int MATRIX_ROWS     = 8;
    localparam int MATRIX_COLS     = 8;
    localparam int MATRIX_ROW_BITS = 3;

    typedef logic [MATRIX_ROW_BITS-1:0] row_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        DISPLAY,
        BLANK
    } scan_state_t;

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Renderer/matrix-side bundle for matrix_scan_driver.
// MATRIX_SCAN_PWM_EN adds the brightness input.
interface matrix_scan_driver_if #(
    parameter int ROWS     = pong_pkg::MATRIX_ROWS,
    parameter int COLS     = pong_pkg::MATRIX_COLS,
    parameter int ROW_BITS = pong_pkg::MATRIX_ROW_BITS
);
    logic                enable;
    logic [15:0]         row_data;
    logic [ROW_BITS-1:0] count;
    logic [ROWS-1:0]     row_sel;
    logic [COLS-1:0]     col_out;
    logic                frame_start;
`ifdef MATRIX_SCAN_PWM_EN
    logic [3:0]          brightness;

    modport master (
        output enable, row_data, brightness,
        input  count, row_sel, col_out, frame_start
    );
    modport slave (
        input  enable, row_data, brightness,
        output count, row_sel, col_out, frame_start
    );
`else
    modport master (
        output enable, row_data,
        input  count, row_sel, col_out, frame_start
    );
    modport slave (
        input  enable, row_data,
        output count, row_sel, col_out, frame_start
    );
`endif
endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter; zero flags the last cycle of the current interval.
module scan_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);
    logic [WIDTH-1:0] value;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    assign zero = (value == '0);
endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexing scan driver for the 8x8 pong LED matrix.
// Optional MATRIX_SCAN_PWM_EN: per-row column PWM from brightness.
module matrix_scan_driver
    import pong_pkg::*;
#(
    parameter int ROWS         = MATRIX_ROWS,
    parameter int COLS         = MATRIX_COLS,
    parameter int ROW_BITS     = MATRIX_ROW_BITS,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int RENDER_LAT   = 1
) (
    input  logic clk,
    input  logic reset,
    matrix_scan_driver_if.slave bus
);
    localparam int MAX_DB = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int MAXC   = (MAX_DB > RENDER_LAT) ? MAX_DB : RENDER_LAT;
    localparam int TW     = $clog2(MAXC + 1);

    scan_state_t         state;
    logic                zero;
    logic                load;
    logic [TW-1:0]       load_val;
    logic [ROW_BITS-1:0] count_next;
    logic [COLS-1:0]     pattern;
    logic                unused_row_data;

    assign pattern         = bus.row_data[COLS-1:0];
    assign unused_row_data = ^bus.row_data[15:COLS];
    assign count_next      = (bus.count == ROW_BITS'(ROWS - 1))
                           ? '0 : bus.count + ROW_BITS'(1);

`ifdef MATRIX_SCAN_PWM_EN
    localparam int SLOT = (DWELL_CYCLES / 16 < 1) ? 1 : DWELL_CYCLES / 16;

    logic [COLS-1:0] cols;
    logic [3:0]      bright;
    logic [TW-1:0]   slot_cnt;
    logic [TW-1:0]   phase;
    logic            slot_end;
    logic [TW-1:0]   phase_next;

    assign slot_end   = (slot_cnt == TW'(SLOT - 1));
    assign phase_next = slot_end ? phase + TW'(1) : phase;
`endif

    // Timer reload happens on the same edge as the state change it times.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        unique case (state)
            IDLE: if (bus.enable) begin
                load     = 1'b1;
                load_val = TW'(RENDER_LAT - 1);
            end
            REQUEST: if (zero) begin
                load     = 1'b1;
                load_val = TW'(DWELL_CYCLES - 1);
            end
            DISPLAY: if (zero) begin
                load     = 1'b1;
                load_val = TW'(BLANK_CYCLES - 1);
            end
            BLANK: if (zero && bus.enable) begin
                load     = 1'b1;
                load_val = TW'(RENDER_LAT - 1);
            end
            default: ;
        endcase
    end

    scan_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.count       <= '0;
            bus.row_sel     <= '0;
            bus.col_out     <= '0;
            bus.frame_start <= 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
            cols            <= '0;
            bright          <= '0;
            slot_cnt        <= '0;
            phase           <= '0;
`endif
        end else begin
            bus.frame_start <= 1'b0;
            unique case (state)
                IDLE: if (bus.enable) begin
                    state     <= REQUEST;
                    bus.count <= '0;
                end
                REQUEST: if (zero) begin
                    state           <= DISPLAY;
                    bus.row_sel     <= ROWS'(1) << bus.count;
                    bus.col_out     <= pattern;
                    bus.frame_start <= (bus.count == '0);
`ifdef MATRIX_SCAN_PWM_EN
                    cols            <= pattern;
                    bright          <= bus.brightness;
                    slot_cnt        <= '0;
                    phase           <= '0;
`endif
                end
                DISPLAY: begin
                    if (zero) begin
                        state       <= BLANK;
                        bus.row_sel <= '0;
                        bus.col_out <= '0;
                    end else begin
`ifdef MATRIX_SCAN_PWM_EN
                        slot_cnt    <= slot_end ? '0 : slot_cnt + TW'(1);
                        phase       <= phase_next;
                        bus.col_out <= (int'(phase_next) <= int'(bright))
                                     ? cols : '0;
`endif
                    end
                end
                BLANK: if (zero) begin
                    if (bus.enable) begin
                        state     <= REQUEST;
                        bus.count <= count_next;
                    end else begin
                        state     <= IDLE;
                        bus.count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
